// File: rtl/if_id_buffer_pkg.sv
// Shared fetch/decode definitions: datapath width, the bubble instruction and
// the fetch packet layout that both stages agree on.
package if_id_buffer_pkg;

    localparam int IF_ID_XLEN = 32;
    localparam logic [IF_ID_XLEN-1:0] IF_ID_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [IF_ID_XLEN-1:0] instr;
        logic [IF_ID_XLEN-1:0] pc;
        logic [IF_ID_XLEN-1:0] pcp4;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_storage.sv
// Entry array for the IF/ID queue: one synchronous write port, one
// combinational read port so the head is visible the cycle after it lands.
module if_id_storage #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    // Contents are don't-care after reset, so entries carry no reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (we && (waddr == AW'(gi))) begin
                mem_reg[gi] <= wdata;
            end
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling queue: captures fetch words, hands them to decode with
// valid/ready, throttles fetch so nothing in flight is lost, flushes on jump.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int               XLEN      = IF_ID_XLEN,
    parameter int               DEPTH     = 4,
    parameter logic [XLEN-1:0]  NOP_INSTR = IF_ID_NOP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_instr,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_pcp4,
    input  logic                       flush,
    output logic                       fetch_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pcp4,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW:0]   FE_LIMIT = (CW+1)'(DEPTH - 1);

    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              fetch_en_reg, ovf_reg;
    logic              push, pop, drop, full;
    logic [CW:0]       occ_next, fe_sum;
    logic [3*XLEN-1:0] wr_data, rd_data;

    assign full = (count_reg == FULL_CNT);
    assign out_valid = (count_reg != '0);
    assign pop  = out_valid & out_ready & ~flush;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push = in_valid & ~flush & (~full | pop);
    assign drop = in_valid & ~flush & full & ~pop;

    assign occ_next = flush ? '0
                    : {1'b0, count_reg} + (CW+1)'(push) - (CW+1)'(pop);
    // Reserve a slot for the word requested now, which arrives next cycle.
    assign fe_sum = occ_next + (CW+1)'(fetch_en_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            fetch_en_reg <= 1'b1;
            ovf_reg      <= 1'b0;
        end else begin
            count_reg    <= occ_next[CW-1:0];
            fetch_en_reg <= (fe_sum <= FE_LIMIT);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (flush) begin
                rd_ptr_reg <= wr_ptr_reg;
            end else if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (drop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign wr_data = {in_instr, in_pc, in_pcp4};

    if_id_storage #(
        .WIDTH (3*XLEN),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (wr_data),
        .raddr (rd_ptr_reg),
        .rdata (rd_data)
    );

    always_comb begin
        out_instr = NOP_INSTR;
        out_pc    = '0;
        out_pcp4  = '0;
        if (out_valid) begin
            out_instr = rd_data[3*XLEN-1:2*XLEN];
            out_pc    = rd_data[2*XLEN-1:XLEN];
            out_pcp4  = rd_data[XLEN-1:0];
        end
    end

    assign fetch_en = fetch_en_reg;
    assign count    = count_reg;
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: expected packets are queued as words are
// accepted and compared against the head presented to decode each cycle.
module tb_if_id_buffer;
    import if_id_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0, in_pcp4 = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        fetch_en, out_valid, ovf;
    logic [31:0] out_instr, out_pc, out_pcp4;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_pkt_t sb_q[$];
    logic       exp_fe  = 1'b1;
    logic       exp_ovf = 1'b0;

    if_id_buffer #(.XLEN(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_pcp4   (in_pcp4),
        .flush     (flush),
        .fetch_en  (fetch_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_pcp4  (out_pcp4),
        .count     (count),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        check("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            check("out_instr", 64'(out_instr), 64'(sb_q[0].instr));
            check("out_pc",    64'(out_pc),    64'(sb_q[0].pc));
            check("out_pcp4",  64'(out_pcp4),  64'(sb_q[0].pcp4));
        end else begin
            check("nop_instr", 64'(out_instr), 64'(NOP));
            check("empty_pc",  64'(out_pc),    64'd0);
            check("empty_pcp4", 64'(out_pcp4), 64'd0);
        end
        check("count",    64'(count),    64'(sb_q.size()));
        check("fetch_en", 64'(fetch_en), 64'(exp_fe));
        check("ovf",      64'(ovf),      64'(exp_ovf));
    endtask

    // One clock: drive inputs, predict the queue, then compare after the edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic fl, input logic rdy);
        logic pop_m, push_m, drop_m;
        int   occ;
        fetch_pkt_t pkt;
        pkt.instr = 32'h0010_0093 ^ (pc << 8);
        pkt.pc    = pc;
        pkt.pcp4  = pc + 32'd4;
        in_valid  = v;
        in_instr  = pkt.instr;
        in_pc     = pkt.pc;
        in_pcp4   = pkt.pcp4;
        flush     = fl;
        out_ready = rdy;
        pop_m  = (sb_q.size() != 0) && rdy && !fl;
        push_m = v && !fl && ((sb_q.size() < DEPTH) || pop_m);
        drop_m = v && !fl && (sb_q.size() == DEPTH) && !pop_m;
        occ    = fl ? 0 : sb_q.size() + int'(push_m) - int'(pop_m);
        @(posedge clk);
        exp_fe = ((occ + int'(exp_fe)) <= DEPTH - 1);
        if (drop_m) exp_ovf = 1'b1;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (pop_m) begin
                $display("pop  pc=%08h pcp4=%08h instr=%08h", sb_q[0].pc, sb_q[0].pcp4, sb_q[0].instr);
                void'(sb_q.pop_front());
            end
            if (push_m) sb_q.push_back(pkt);
        end
        #1;
        check_state();
    endtask

    task automatic reset_model();
        sb_q.delete();
        exp_fe  = 1'b1;
        exp_ovf = 1'b0;
    endtask

    initial begin
        // Reset and idle.
        #12;
        check_state();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Fill three words without draining; fetch_en must drop.
        cycle(1, 32'h00, 0, 0);
        cycle(1, 32'h04, 0, 0);
        cycle(1, 32'h08, 0, 0);
        check("fe_low_at_3", 64'(fetch_en), 64'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

        // Streaming: one in, one out per cycle.
        for (int i = 0; i < 20; i++) cycle(1, 32'h100 + 32'(i * 4), 0, 1);
        check("stream_count", 64'(count), 64'd1);
        check("stream_fe",    64'(fetch_en), 64'd1);
        cycle(0, 0, 0, 1);

        // Two queued, then flush with a wrong-path word arriving.
        cycle(1, 32'h20, 0, 0);
        cycle(1, 32'h24, 0, 0);
        cycle(1, 32'h40, 1, 1);
        check("flush_empty", 64'(out_valid), 64'd0);
        cycle(1, 32'h80, 0, 0);
        check("redirect_pc", 64'(out_pc), 64'h80);
        cycle(0, 0, 0, 1);

        // Full queue plus flush with a word: flush wins, no overflow.
        for (int i = 0; i < 4; i++) cycle(1, 32'h200 + 32'(i * 4), 0, 0);
        cycle(1, 32'h300, 1, 0);
        check("flush_full_ovf", 64'(ovf), 64'd0);

        // Ignore fetch_en: the fifth word overflows.
        for (int i = 0; i < 5; i++) cycle(1, 32'h400 + 32'(i * 4), 0, 0);
        check("ovf_count", 64'(count), 64'd4);
        check("ovf_set",   64'(ovf),   64'd1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("ovf_sticky", 64'(ovf), 64'd1);

        // Asynchronous reset mid-drain, between edges.
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_state();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 32'h500, 0, 0);
        cycle(0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Receiving end of the fetch-stage output interface: captures {instr, pc, pcp4} qualified by fetch's decode_en.
- Holds the words in a small circular queue and presents them to decode with a valid/ready handshake.
- Drives the fetch enable so that no in-flight word is lost.
- Flushes on a jump, so decode never sees wrong-path instructions.

Parameters:
- XLEN, 32, datapath width of instr/pc/pcp4.
- DEPTH, 4, queue entries. Power of two, ≥2. Full throughput requires ≥3.
- NOP_INSTR, 32'h00000013, value driven on out_instr while out_valid=0.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  fetch decode_en; a word is present this cycle.
- in_instr  input  XLEN  fetched instruction.
- in_pc  input  XLEN  pc of the instruction.
- in_pcp4  input  XLEN  pc+4 of the instruction.
- flush  input  1  jump taken (fetch jmp); discards the queue.
- fetch_en  output  1  enable to fetch; registered.
- out_valid  output  1  head entry valid to decode.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  XLEN  head instr, or NOP_INSTR when empty.
- out_pc  output  XLEN  head pc, 0 when empty.
- out_pcp4  output  XLEN  head pcp4, 0 when empty.
- count  output  $clog2(DEPTH+1)  occupancy.
- ovf  output  1  sticky overflow error flag.

Behaviour:
- Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, out_valid=0, ovf=0, fetch_en=1. out_instr=NOP_INSTR, out_pc=out_pcp4=0. Storage contents are don't-care.
- push = in_valid & !flush. pop = out_valid & out_ready & !flush.
- Push writes the entry at wr_ptr, then wr_ptr++. Pop sets rd_ptr++. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- occ_next = count + push - pop; count <= occ_next.
- out_valid = (count != 0), combinational from registered state. The out_* fields read the entry at rd_ptr, or the empty defaults.
- Latency: a word pushed in cycle t is visible on out_* in cycle t+1. There is no same-cycle bypass.
- Push and pop in the same cycle with 0<count<DEPTH: both occur, count unchanged.
- Push and pop with count==DEPTH: both occur, count stays DEPTH, no overflow.
- Push with count==DEPTH and no pop: the word is dropped, state is unchanged, and ovf<=1. ovf stays set until reset.
- Pop while empty is impossible, since out_valid=0.
- Flow control: fetch_en <= (occ_next + fetch_en <= DEPTH-1). This reserves space for the word requested this cycle, which arrives next cycle. With legal fetch behaviour (1-cycle en to decode_en latency), ovf never sets.
- Flush (flush=1):
  - count<=0 and rd_ptr<=wr_ptr.
  - Any in_valid in the same cycle is discarded, and out_ready is ignored.
  - out_valid=0 from the next cycle.
  - fetch_en is computed with occ_next=0.
  - Words arriving in later cycles are the redirected stream and are accepted normally.
- Flush with in_valid=1 and count==DEPTH: the flush wins and ovf is not set.
- Reset mid-stream: all state returns to reset values immediately, independent of clk.

Decomposition:
- Shared package: XLEN and NOP_INSTR constants, plus a typedef for the fetch packet {instr, pc, pcp4}, so fetch and decode stages share one definition.
- One natural sub-module, if_id_storage: a DEPTH x 3*XLEN register array with one synchronous write port and one combinational read port, written at wr_ptr on push and read at rd_ptr.
- Pointer, count, flow-control and flush logic stay in if_id_buffer.

Test Plan:
- Reset, then idle: out_valid=0, out_instr=32'h00000013, count=0, fetch_en=1, ovf=0.
- Push pc=0x00, 0x04, 0x08 on consecutive cycles with out_ready=0, DEPTH=4:
  - count reaches 3 and fetch_en falls to 0 by the cycle the third word lands.
  - Setting out_ready=1 then drains the words in order, with pcp4=0x04, 0x08, 0x0C.
- Continuous in_valid with out_ready=1 for 20 words: out_valid=1 every cycle from cycle 2, pc increments by 4 each cycle, count holds at 1, fetch_en stays 1.
- Two words queued, then flush=1 together with in_valid=1 (pc=0x40):
  - Next cycle: count=0 and out_valid=0.
  - A word with pc=0x80 the following cycle appears as the head one cycle later; 0x40 is never output.
- Force in_valid=1 for 5 cycles with out_ready=0 while ignoring fetch_en: the 5th word is dropped, count=4, ovf=1 and remains 1 until rst is asserted low.
- Assert rst low mid-drain, between clock edges: all outputs go to reset values without a clock edge.
